// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard controller.
// Stage records are split into a flag struct and a parametrised destination field.
package fwd_pkg;

  // Forward-select value that means "read the register file".
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic valid;
    logic regwr;
    logic is_load;
  } stage_flags_t;

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_stage_tracker.sv
// Shadow pipeline of in-flight instruction records (stage 1 = EX .. stage DEPTH = WB).
// Shifts one stage per cycle unless frozen; stage 1 takes whatever record the top presents.
module fwd_stage_tracker
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned REG_AW = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          freeze,
  input  stage_flags_t                  in_flags,
  input  logic [REG_AW-1:0]             in_dst,
  output stage_flags_t [DEPTH:1]        st_flags,
  output logic [DEPTH:1][REG_AW-1:0]    st_dst
);

  stage_flags_t [DEPTH:1]     flags_q, flags_d;
  logic [DEPTH:1][REG_AW-1:0] dst_q, dst_d;

  always_comb begin
    flags_d = flags_q;
    dst_d   = dst_q;
    if (!freeze) begin
      flags_d[1] = in_flags;
      dst_d[1]   = in_dst;
      for (int k = 2; k <= int'(DEPTH); k++) begin
        flags_d[k] = flags_q[k-1];
        dst_d[k]   = dst_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      dst_q   <= '0;
    end else begin
      flags_q <= flags_d;
      dst_q   <= dst_d;
    end
  end

  assign st_flags = flags_q;
  assign st_dst   = dst_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall generation for the in-order pipeline.
// The youngest matching in-flight writer decides each source; loads too young stall ID.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_AVAIL = 2,
  parameter int unsigned SEL_W      = sel_width(DEPTH),
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           id_dst_addr,
  input  logic                        id_regwr,
  input  logic                        id_is_load,
  input  logic                        flush,
  input  logic                        mem_busy,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall_id,
  output logic                        freeze,
  output logic [CNT_W-1:0]            stall_cnt
);

  stage_flags_t [DEPTH:1]     st_flags;
  logic [DEPTH:1][REG_AW-1:0] st_dst;
  stage_flags_t               in_flags;
  logic [NUM_SRC-1:0]         hazard;
  logic [CNT_W-1:0]           cnt_q;

  assign freeze = mem_busy;

  // A stalled or flushed ID instruction must not enter EX; a bubble goes in instead.
  always_comb begin
    in_flags = '0;
    if (id_valid && !stall_id && !flush) begin
      in_flags.valid   = 1'b1;
      in_flags.regwr   = id_regwr;
      in_flags.is_load = id_is_load;
    end
  end

  fwd_stage_tracker #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .freeze   (freeze),
    .in_flags (in_flags),
    .in_dst   (id_dst_addr),
    .st_flags (st_flags),
    .st_dst   (st_dst)
  );

  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_src
    logic [REG_AW-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic              haz;

    assign addr = id_src_addr[i*REG_AW +: REG_AW];

    // Walk oldest to youngest so the youngest match overrides everything older.
    always_comb begin
      sel = SEL_W'(FWD_RF);
      haz = 1'b0;
      for (int k = int'(DEPTH); k >= 1; k--) begin
        if (id_src_used[i] && (addr != '0) && st_flags[k].valid && st_flags[k].regwr &&
            (st_dst[k] == addr)) begin
          if (st_flags[k].is_load && (k < int'(LOAD_AVAIL))) begin
            sel = SEL_W'(FWD_RF);
            haz = 1'b1;
          end else begin
            sel = SEL_W'(k);
            haz = 1'b0;
          end
        end
      end
    end

    assign fwd_sel[i*SEL_W +: SEL_W] = sel;
    assign hazard[i]                 = haz;
  end

  assign stall_id = id_valid & ~flush & (|hazard);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_id && !freeze && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus randomized traffic
// compared against an array-based model of the in-flight instruction window.
module tb_fwd_hazard_ctrl;
  localparam int unsigned NUM_SRC    = 2;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned DEPTH      = 3;
  localparam int unsigned LOAD_AVAIL = 2;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned CNT_W      = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_dst_addr;
  logic                      id_regwr;
  logic                      id_is_load;
  logic                      flush;
  logic                      mem_busy;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall_id;
  logic                      freeze;
  logic [CNT_W-1:0]          stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model of the in-flight window: entry k is the instruction k stages past ID.
  bit          mv[1:DEPTH];
  int unsigned md[1:DEPTH];
  bit          mr[1:DEPTH];
  bit          ml[1:DEPTH];
  int unsigned m_cnt;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .NUM_SRC    (NUM_SRC),
    .REG_AW     (REG_AW),
    .DEPTH      (DEPTH),
    .LOAD_AVAIL (LOAD_AVAIL),
    .SEL_W      (SEL_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src_addr (id_src_addr),
    .id_src_used (id_src_used),
    .id_dst_addr (id_dst_addr),
    .id_regwr    (id_regwr),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .mem_busy    (mem_busy),
    .fwd_sel     (fwd_sel),
    .stall_id    (stall_id),
    .freeze      (freeze),
    .stall_cnt   (stall_cnt)
  );

  // First (youngest) in-flight writer of the source register, 0 if none.
  function automatic int m_writer(int i);
    int unsigned a;
    a = id_src_addr[i*REG_AW +: REG_AW];
    if (!id_src_used[i] || a == 0) return 0;
    for (int k = 1; k <= int'(DEPTH); k++)
      if (mv[k] && mr[k] && md[k] == a) return k;
    return 0;
  endfunction

  function automatic bit m_haz(int i);
    int w;
    w = m_writer(i);
    return (w != 0) && ml[w] && (w < int'(LOAD_AVAIL));
  endfunction

  function automatic logic [NUM_SRC*SEL_W-1:0] m_sel_vec();
    logic [NUM_SRC*SEL_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NUM_SRC); i++)
      if (!m_haz(i)) v[i*SEL_W +: SEL_W] = SEL_W'(m_writer(i));
    return v;
  endfunction

  function automatic bit m_stall();
    bit h;
    h = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) h |= m_haz(i);
    return id_valid && !flush && h;
  endfunction

  task automatic cycle();
    bit st, adv, rs, nv, rw, ld;
    int unsigned dst;
    st  = m_stall();
    adv = !mem_busy;
    rs  = rst_n;
    nv  = id_valid && !st && !flush;
    dst = id_dst_addr;
    rw  = id_regwr;
    ld  = id_is_load;
    @(posedge clk);
    if (!rs) begin
      for (int k = 1; k <= int'(DEPTH); k++) mv[k] = 1'b0;
      m_cnt = 0;
    end else if (adv) begin
      for (int k = int'(DEPTH); k >= 2; k--) begin
        mv[k] = mv[k-1]; md[k] = md[k-1]; mr[k] = mr[k-1]; ml[k] = ml[k-1];
      end
      mv[1] = nv; md[1] = dst; mr[1] = rw; ml[1] = ld;
      if (st && m_cnt != (32'd1 << CNT_W) - 1) m_cnt++;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] used,
                       input int dst, input bit rw, input bit ld, input bit fl, input bit mb);
    id_valid    = v;
    id_src_addr = {REG_AW'(s1), REG_AW'(s0)};
    id_src_used = used;
    id_dst_addr = REG_AW'(dst);
    id_regwr    = rw;
    id_is_load  = ld;
    flush       = fl;
    mem_busy    = mb;
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (DEPTH) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 3, 3, 2'b11, 3, 1, 0, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    drive(1, 3, 3, 2'b11, 0, 0, 0, 0, 0);
    checks++; if (fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL reset_sel got=%h exp=0", fwd_sel); end
    checks++; if (stall_id !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b exp=0", stall_id); end
    checks++; if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (freeze !== 1'b0) begin
      errors++; $display("FAIL reset_freeze got=%b exp=0", freeze); end
  endtask

  task automatic test_alu_chain();
    logic [3:0] exp_sel [4] = '{4'b0001, 4'b0010, 4'b0011, 4'b0000};
    drain();
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    cycle();
    for (int n = 0; n < 4; n++) begin
      drive(1, 3, 7, 2'b11, 0, 0, 0, 0, 0);
      checks++; if (fwd_sel !== exp_sel[n]) begin
        errors++; $display("FAIL alu_sel%0d got=%h exp=%h", n, fwd_sel, exp_sel[n]); end
      checks++; if (stall_id !== 1'b0) begin
        errors++; $display("FAIL alu_stall%0d got=%b exp=0", n, stall_id); end
      cycle();
    end
  endtask

  task automatic test_load_use();
    drain();
    drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
    cycle();
    drive(1, 6, 5, 2'b11, 6, 1, 0, 0, 0);
    checks++; if (stall_id !== 1'b1 || fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL lu_stall got=%b/%h exp=1/0", stall_id, fwd_sel); end
    cycle();
    // src0 reads r6: the held add must not have entered EX during the stall.
    checks++; if (fwd_sel !== 4'b1000) begin
      errors++; $display("FAIL lu_resolve_sel got=%h exp=8", fwd_sel); end
    checks++; if (stall_id !== 1'b0) begin
      errors++; $display("FAIL lu_resolve_stall got=%b exp=0", stall_id); end
    checks++; if (stall_cnt !== CNT_W'(m_cnt) || m_cnt != 1) begin
      errors++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    cycle();
  endtask

  task automatic test_priority();
    drain();
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); cycle();
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0); cycle();
    drive(1, 4, 4, 2'b11, 0, 0, 0, 0, 0);
    checks++; if (fwd_sel !== 4'b0101 || stall_id !== 1'b0) begin
      errors++; $display("FAIL prio_alu got=%h/%b exp=5/0", fwd_sel, stall_id); end
    drain();
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); cycle();
    drive(1, 0, 0, 2'b00, 4, 1, 1, 0, 0); cycle();
    drive(1, 4, 4, 2'b11, 0, 0, 0, 0, 0);
    checks++; if (fwd_sel !== 4'b0000 || stall_id !== 1'b1) begin
      errors++; $display("FAIL prio_load got=%h/%b exp=0/1", fwd_sel, stall_id); end
    cycle();
    checks++; if (fwd_sel !== 4'b1010 || stall_id !== 1'b0) begin
      errors++; $display("FAIL prio_resolve got=%h/%b exp=a/0", fwd_sel, stall_id); end
  endtask

  task automatic test_zero_unused();
    drain();
    drive(1, 0, 0, 2'b00, 0, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 2'b11, 9, 1, 0, 0, 0);
    checks++; if (fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL zero_sel got=%h exp=0", fwd_sel); end
    cycle();
    drive(1, 9, 9, 2'b10, 0, 0, 0, 0, 0);
    checks++; if (fwd_sel !== 4'b0100) begin
      errors++; $display("FAIL unused_alu got=%h exp=4", fwd_sel); end
    drain();
    drive(1, 0, 0, 2'b00, 9, 1, 1, 0, 0); cycle();
    drive(1, 9, 9, 2'b00, 0, 0, 0, 0, 0);
    checks++; if (fwd_sel !== 4'b0000 || stall_id !== 1'b0) begin
      errors++; $display("FAIL unused_load got=%h/%b exp=0/0", fwd_sel, stall_id); end
    drive(1, 9, 9, 2'b01, 0, 0, 0, 0, 0);
    checks++; if (stall_id !== 1'b1) begin
      errors++; $display("FAIL used_load got=%b exp=1", stall_id); end
    drive(0, 9, 9, 2'b01, 0, 0, 0, 0, 0);
    checks++; if (stall_id !== 1'b0) begin
      errors++; $display("FAIL invalid_id got=%b exp=0", stall_id); end
  endtask

  task automatic test_freeze();
    drain();
    drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); cycle();
    drive(1, 0, 5, 2'b11, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3; n++) begin
      checks++; if (stall_id !== 1'b1 || freeze !== 1'b1 || fwd_sel !== 4'b0000) begin
        errors++;
        $display("FAIL frz_hold%0d got=%b/%b/%h exp=1/1/0", n, stall_id, freeze, fwd_sel);
      end
      cycle();
      checks++; if (stall_cnt !== CNT_W'(m_cnt)) begin
        errors++; $display("FAIL frz_cnt%0d got=%0d exp=%0d", n, stall_cnt, m_cnt); end
    end
    drive(1, 0, 5, 2'b11, 0, 0, 0, 0, 0);
    checks++; if (stall_id !== 1'b1 || freeze !== 1'b0) begin
      errors++; $display("FAIL frz_release got=%b/%b exp=1/0", stall_id, freeze); end
    cycle();
    checks++; if (fwd_sel !== 4'b1000 || stall_id !== 1'b0) begin
      errors++; $display("FAIL frz_resolve got=%h/%b exp=8/0", fwd_sel, stall_id); end
    checks++; if (stall_cnt !== CNT_W'(m_cnt)) begin
      errors++; $display("FAIL frz_cnt_end got=%0d exp=%0d", stall_cnt, m_cnt); end
  endtask

  task automatic test_flush_reset();
    drain();
    drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); cycle();
    drive(1, 0, 5, 2'b11, 7, 1, 0, 1, 0);
    checks++; if (stall_id !== 1'b0) begin
      errors++; $display("FAIL flush_stall got=%b exp=0", stall_id); end
    cycle();
    drive(1, 7, 5, 2'b11, 0, 0, 0, 0, 0);
    checks++; if (fwd_sel !== 4'b1000) begin
      errors++; $display("FAIL flush_bubble got=%h exp=8", fwd_sel); end
    drain();
    drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); cycle();
    drive(1, 0, 5, 2'b11, 0, 0, 0, 0, 1);
    checks++; if (stall_id !== 1'b1) begin
      errors++; $display("FAIL rst_pre got=%b exp=1", stall_id); end
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (fwd_sel !== 4'b0000 || stall_id !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_frz got=%h/%b/%0d exp=0/0/0", fwd_sel, stall_id, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      checks++; if (fwd_sel !== m_sel_vec()) begin
        errors++; $display("FAIL rnd_sel n=%0d got=%h exp=%h", n, fwd_sel, m_sel_vec()); end
      checks++; if (stall_id !== m_stall()) begin
        errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_id, m_stall()); end
      checks++; if (freeze !== mem_busy) begin
        errors++; $display("FAIL rnd_freeze n=%0d got=%b exp=%b", n, freeze, mem_busy); end
      checks++; if (stall_cnt !== CNT_W'(m_cnt)) begin
        errors++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_cnt); end
      cycle();
    end
  endtask

  initial begin
    for (int k = 1; k <= int'(DEPTH); k++) begin
      mv[k] = 1'b0; md[k] = 0; mr[k] = 1'b0; ml[k] = 1'b0;
    end
    m_cnt = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority();
    test_zero_unused();
    test_freeze();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
